// File: rtl/painel_esteira.sv
// Operator panel front-end for the conveyor counter: synchronizes and debounces the
// push-buttons, edge-detects the item sensor, decodes the counter displays and arbitrates commands.
module painel_esteira #(
   parameter int         DEB_CYCLES = 4,
   parameter logic [3:0] META       = 4'hA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_cont,
   input  logic       btn_para,
   input  logic       btn_perigo,
   input  logic       sensor_raw,
   input  logic [6:0] display_c,
   input  logic [6:0] display_i,
   output logic       continuar,
   output logic       parada,
   output logic       perigo,
   output logic       sensor,
   output logic [3:0] cnt_c,
   output logic [3:0] cnt_i,
   output logic       seg_err,
   output logic       meta_hit
);

   localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

   // Button vectors: bit 0 continuar, bit 1 parada, bit 2 perigo.
   logic [2:0]       btn_raw;
   logic [2:0]       btn_sync_p0, btn_sync_p1;
   logic [2:0][3:0]  deb_cnt;
   logic [2:0]       deb_st, deb_st_d;
   logic [2:0]       cand_p2;
   logic             sen_sync_p0, sen_sync_p1, sen_d, sen_edge_p2;
   logic             meta_hit_d, auto_stop;
   logic             cont_n, para_n, peri_n;
   logic [4:0]       dec_c, dec_i;
   logic [3:0]       cnt_c_n, cnt_i_n;

   assign btn_raw = {btn_perigo, btn_para, btn_cont};

   // Returns {valid, value}; anything outside the table decodes as invalid.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'b1111110: seg_decode = {1'b1, 4'h0};
         7'b0110000: seg_decode = {1'b1, 4'h1};
         7'b1101101: seg_decode = {1'b1, 4'h2};
         7'b1111001: seg_decode = {1'b1, 4'h3};
         7'b0110011: seg_decode = {1'b1, 4'h4};
         7'b1011011: seg_decode = {1'b1, 4'h5};
         7'b1011111: seg_decode = {1'b1, 4'h6};
         7'b1110000: seg_decode = {1'b1, 4'h7};
         7'b1111111: seg_decode = {1'b1, 4'h8};
         7'b1111011: seg_decode = {1'b1, 4'h9};
         7'b1110111: seg_decode = {1'b1, 4'hA};
         7'b0011111: seg_decode = {1'b1, 4'hB};
         7'b1001110: seg_decode = {1'b1, 4'hC};
         7'b0111101: seg_decode = {1'b1, 4'hD};
         7'b1001111: seg_decode = {1'b1, 4'hE};
         7'b1000111: seg_decode = {1'b1, 4'hF};
         default:    seg_decode = 5'b0_0000;
      endcase
   endfunction

   // Stage p0/p1: synchronizers; then debounce and rising-edge candidates (p2).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sync_p0 <= '0;
         btn_sync_p1 <= '0;
         deb_cnt     <= '0;
         deb_st      <= '0;
         deb_st_d    <= '0;
         cand_p2     <= '0;
         sen_sync_p0 <= 1'b0;
         sen_sync_p1 <= 1'b0;
         sen_d       <= 1'b0;
         sen_edge_p2 <= 1'b0;
      end else begin
         btn_sync_p0 <= btn_raw;
         btn_sync_p1 <= btn_sync_p0;
         for (int i = 0; i < 3; i++) begin
            if (btn_sync_p1[i] == deb_st[i]) begin
               deb_cnt[i] <= 4'd0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_st[i]  <= btn_sync_p1[i];
               deb_cnt[i] <= 4'd0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 4'd1;
            end
         end
         deb_st_d    <= deb_st;
         cand_p2     <= deb_st & ~deb_st_d;
         sen_sync_p0 <= sensor_raw;
         sen_sync_p1 <= sen_sync_p0;
         sen_d       <= sen_sync_p1;
         sen_edge_p2 <= sen_sync_p1 & ~sen_d;
      end
   end

   // Lower-priority candidates in the same cycle are dropped, never queued.
   assign auto_stop = meta_hit & ~meta_hit_d;

   always_comb begin
      peri_n = cand_p2[2];
      para_n = ~cand_p2[2] & (cand_p2[1] | auto_stop);
      cont_n = ~cand_p2[2] & ~cand_p2[1] & ~auto_stop & cand_p2[0];
   end

   always_comb begin
      dec_c   = seg_decode(display_c);
      dec_i   = seg_decode(display_i);
      cnt_c_n = dec_c[4] ? dec_c[3:0] : cnt_c;
      cnt_i_n = dec_i[4] ? dec_i[3:0] : cnt_i;
   end

   // Output stage: commands, sensor pulse and decoded displays.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         continuar  <= 1'b0;
         parada     <= 1'b0;
         perigo     <= 1'b0;
         sensor     <= 1'b0;
         cnt_c      <= 4'h0;
         cnt_i      <= 4'h0;
         seg_err    <= 1'b0;
         meta_hit   <= 1'b0;
         meta_hit_d <= 1'b0;
      end else begin
         continuar  <= cont_n;
         parada     <= para_n;
         perigo     <= peri_n;
         sensor     <= sen_edge_p2;
         cnt_c      <= cnt_c_n;
         cnt_i      <= cnt_i_n;
         seg_err    <= ~(dec_c[4] & dec_i[4]);
         meta_hit   <= (cnt_i_n == META);
         meta_hit_d <= meta_hit;
      end
   end

endmodule

// File: tb/tb_painel_esteira.sv
// Directed bench for painel_esteira: command latency, debounce, priority, decoder and sensor.
module tb_painel_esteira;

   localparam logic [6:0] S0 = 7'b1111110;
   localparam logic [6:0] S1 = 7'b0110000;
   localparam logic [6:0] S5 = 7'b1011011;
   localparam logic [6:0] S7 = 7'b1110000;
   localparam logic [6:0] S9 = 7'b1111011;
   localparam logic [6:0] SA = 7'b1110111;
   localparam logic [6:0] SF = 7'b1000111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_cont = 1'b0, btn_para = 1'b0, btn_perigo = 1'b0, sensor_raw = 1'b0;
   logic [6:0] display_c = S0, display_i = S0;
   logic       continuar, parada, perigo, sensor, seg_err, meta_hit;
   logic [3:0] cnt_c, cnt_i;

   int checks = 0;
   int errors = 0;
   int n_cont, n_para, n_peri, n_sen, f_cont, f_para, f_peri, f_sen, multi;

   painel_esteira #(.DEB_CYCLES(4), .META(4'hA)) dut (
      .clk(clk), .rst(rst),
      .btn_cont(btn_cont), .btn_para(btn_para), .btn_perigo(btn_perigo),
      .sensor_raw(sensor_raw), .display_c(display_c), .display_i(display_i),
      .continuar(continuar), .parada(parada), .perigo(perigo), .sensor(sensor),
      .cnt_c(cnt_c), .cnt_i(cnt_i), .seg_err(seg_err), .meta_hit(meta_hit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      n_cont = 0; n_para = 0; n_peri = 0; n_sen = 0;
      f_cont = 0; f_para = 0; f_peri = 0; f_sen = 0;
   endtask

   // Advance n cycles, counting pulses and remembering the cycle of the first one.
   task automatic run(input int n);
      for (int c = 1; c <= n; c++) begin
         tick();
         if (continuar) begin n_cont++; if (f_cont == 0) f_cont = c; end
         if (parada)    begin n_para++; if (f_para == 0) f_para = c; end
         if (perigo)    begin n_peri++; if (f_peri == 0) f_peri = c; end
         if (sensor)    begin n_sen++;  if (f_sen == 0)  f_sen = c;  end
         if (int'(continuar) + int'(parada) + int'(perigo) > 1) multi++;
      end
   endtask

   function automatic logic [31:0] outs();
      return {18'd0, continuar, parada, perigo, sensor, cnt_c, cnt_i, seg_err, meta_hit};
   endfunction

   initial begin
      multi = 0;
      clr();
      tick(); tick(); tick();
      check("reset_outputs", outs(), 32'd0);
      rst = 1'b0;
      run(2);
      check("idle_cnt_c", 32'(cnt_c), 32'd0);
      check("idle_seg_err", 32'(seg_err), 32'd0);

      // Clean press held 20 cycles
      clr(); btn_cont = 1'b1; run(20);
      check("cont_count", n_cont, 1);
      check("cont_latency", f_cont, 8);
      clr(); btn_cont = 1'b0; run(10);
      check("cont_release", n_cont, 0);

      // Bouncing button never stable long enough
      clr();
      for (int k = 0; k < 6; k++) begin
         btn_para = ~btn_para;
         run(2);
      end
      btn_para = 1'b0; run(15);
      check("para_bounce", n_para, 0);

      // Simultaneous perigo and continuar
      clr(); btn_perigo = 1'b1; btn_cont = 1'b1; run(20);
      check("peri_count", n_peri, 1);
      check("peri_latency", f_peri, 8);
      check("peri_blocks_cont", n_cont, 0);
      btn_perigo = 1'b0; btn_cont = 1'b0; run(10);

      // Held through reset release
      btn_cont = 1'b1; rst = 1'b1; tick(); tick(); rst = 1'b0;
      clr(); run(20);
      check("held_rst_count", n_cont, 1);
      check("held_rst_latency", f_cont, 8);
      btn_cont = 1'b0; run(10);

      // Reset mid-debounce discards the press
      clr(); btn_cont = 1'b1; run(3);
      rst = 1'b1; btn_cont = 1'b0; tick(); rst = 1'b0;
      run(15);
      check("rst_mid_debounce", n_cont, 0);

      // Item counter reaches META
      display_i = S9; tick();
      check("cnt_i_9", 32'(cnt_i), 32'h9);
      check("meta_low", 32'(meta_hit), 32'd0);
      display_i = SA; tick();
      check("cnt_i_A", 32'(cnt_i), 32'hA);
      check("meta_high", 32'(meta_hit), 32'd1);
      check("auto_not_yet", 32'(parada), 32'd0);
      clr(); run(11);
      check("auto_count", n_para, 1);
      check("auto_latency", f_para, 1);
      display_i = S0; run(2);

      // Invalid code holds the count
      display_c = S5; tick();
      check("cnt_c_5", 32'(cnt_c), 32'h5);
      display_c = 7'b0000000;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("err_flag", 32'(seg_err), 32'd1);
         check("err_hold", 32'(cnt_c), 32'h5);
      end
      display_c = S1; tick();
      check("cnt_c_1", 32'(cnt_c), 32'h1);
      check("err_clear", 32'(seg_err), 32'd0);
      display_c = SF; tick();
      check("cnt_c_F", 32'(cnt_c), 32'hF);
      display_c = S0; tick();
      check("wrap_cnt_c", 32'(cnt_c), 32'h0);
      check("wrap_no_err", 32'(seg_err), 32'd0);

      // Sensor edges
      clr();
      sensor_raw = 1'b1; run(5);
      sensor_raw = 1'b0; run(2);
      sensor_raw = 1'b1; run(1);
      sensor_raw = 1'b0; run(8);
      check("sensor_count", n_sen, 2);
      check("sensor_latency", f_sen, 4);

      check("one_hot_cmds", multi, 0);

      // Asynchronous reset clears everything at once
      display_c = S7; display_i = SA; run(3);
      check("pre_rst_cnt_c", 32'(cnt_c), 32'h7);
      sensor_raw = 1'b1; run(2);
      rst = 1'b1; #1;
      check("async_rst_outputs", outs(), 32'd0);
      tick(); sensor_raw = 1'b0; rst = 1'b0; run(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/painel_esteira.md
PAINEL_ESTEIRA -- requirements
Module: painel_esteira

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set the number of consecutive stable synchronized cycles a button needs before a level change is accepted (range 2..15).
REQ-002 Parameter META, default 4'hA, SHALL set the decoded item count that triggers an automatic stop.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_cont, btn_para, btn_perigo  input  1 each  raw, bouncy operator push-buttons, active-high, asynchronous to clk.
REQ-006 sensor_raw  input  1  raw item photo-sensor, active-high, asynchronous to clk.
REQ-007 display_c, display_i  input  7 each  segment codes from the conveyor counter, bit order abcdefg, active-high segments.
REQ-008 continuar, parada, perigo  output  1 each  one-cycle command pulses to the conveyor counter.
REQ-009 sensor  output  1  one-cycle item pulse to the conveyor counter.
REQ-010 cnt_c, cnt_i  output  4 each  registered hex values decoded from display_c and display_i.
REQ-011 seg_err  output  1  registered flag, high while either display input holds a non-hex code.
REQ-012 meta_hit  output  1  registered level, high while decoded cnt_i equals META.

Function
REQ-013 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-014 Debounce, per button: the counter SHALL increment each cycle the synchronized level differs from the debounced state, clear to 0 on any cycle they match, and update the debounced state when the count reaches DEB_CYCLES.
REQ-015 A 0->1 transition of a debounced state SHALL produce exactly one candidate pulse; 1->0 transitions and held-high buttons SHALL produce none.
REQ-016 Latency: a clean raw button rise SHALL produce its command pulse on the clock edge 2+DEB_CYCLES+1 edges after the raw rise is first sampled.
REQ-017 Glitches shorter than DEB_CYCLES synchronized cycles SHALL produce no pulse.
REQ-018 sensor SHALL be high for exactly one cycle on each synchronized 0->1 edge of sensor_raw (no debounce), 3 edges after the raw rise is sampled; a held-high sensor_raw SHALL produce only one pulse.
REQ-019 Decoder: codes 0-F SHALL map per the team segment table (0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, B=0011111, C=1001110, D=0111101, E=1001111, F=1000111), registered with 1-cycle latency.
REQ-020 A non-table code SHALL hold the previous cnt value and assert seg_err on the same edge the code is registered; seg_err SHALL clear on the first cycle both inputs are valid again.
REQ-021 Auto-stop: a 0->1 transition of meta_hit SHALL raise an auto-stop request for one cycle; it SHALL not repeat while meta_hit stays high.
REQ-022 Command arbitration, per cycle: perigo candidate > parada candidate or auto-stop > continuar candidate. At most one of continuar/parada/perigo SHALL be high in any cycle; lower-priority candidates in the same cycle SHALL be dropped, not queued.
REQ-023 All outputs SHALL be registered; none SHALL be combinational from any input.
REQ-024 cnt_c wrap F->0 SHALL be decoded normally; wrap is not an error.

Reset
REQ-025 While rst is high, all synchronizer flops, debounce counters, debounced states, edge registers, and outputs SHALL be 0 (cnt_c=cnt_i=0, seg_err=0, meta_hit=0).
REQ-026 A button held high through rst release SHALL be debounced from state 0 and SHALL produce one pulse after the REQ-016 latency.
REQ-027 Asserting rst mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for that press.

Verification
REQ-028 btn_cont rises clean, held 20 cycles, DEB_CYCLES=4 -> continuar high exactly one cycle, 7 edges after the rise; no further pulse.
REQ-029 btn_para toggles every 2 cycles for 12 cycles then settles low -> no parada pulse.
REQ-030 btn_perigo and btn_cont rise on the same edge -> perigo pulses once; continuar never pulses.
REQ-031 display_i steps 9 -> A (1110111), META=A -> cnt_i=A, meta_hit=1, one parada pulse the next cycle; display_i held at A for 10 cycles -> no further parada.
REQ-032 display_c=0000000 for 3 cycles, then 0110000 -> seg_err high 3 cycles, cnt_c holds prior value, then cnt_c=1 and seg_err=0.
REQ-033 sensor_raw high 5 cycles, low 2, high 1 -> exactly two sensor pulses; rst asserted mid-sequence -> all outputs 0 immediately.
